// File: rtl/icache_fill_ctrl_if.sv
// Fetch-miss, instruction-memory and tag/data-bank write signals of the I-cache fill controller.
// The controller connects through the master modport. The miss logic, the memory and the banks
// connect through the slave modport.
interface icache_fill_ctrl_if #(
  parameter int WAYS            = 2,
  parameter int LINE_ADDR_W     = 6,
  parameter int SUB_LINE_ADDR_W = 2
);
  logic                                   miss_req;
  logic [31:0]                            miss_addr;
  logic                                   mem_request;
  logic [31:0]                            mem_addr;
  logic                                   mem_ack;
  logic                                   mem_data_valid;
  logic [31:0]                            mem_data;
  logic [WAYS-1:0]                        data_bank_wen;
  logic [LINE_ADDR_W+SUB_LINE_ADDR_W-1:0] data_bank_addr;
  logic [31:0]                            data_bank_data;
  logic                                   update;
  logic [WAYS-1:0]                        update_way;
  logic                                   busy;
  logic                                   fill_done;

  modport master (
    input  miss_req, miss_addr, mem_ack, mem_data_valid, mem_data,
    output mem_request, mem_addr, data_bank_wen, data_bank_addr, data_bank_data,
           update, update_way, busy, fill_done
  );

  modport slave (
    output miss_req, miss_addr, mem_ack, mem_data_valid, mem_data,
    input  mem_request, mem_addr, data_bank_wen, data_bank_addr, data_bank_data,
           update, update_way, busy, fill_done
  );
endinterface

// File: rtl/icache_fill_ctrl.sv
// I-cache line-fill controller. On a miss it requests the line, writes the returned words into
// the round-robin victim way, and writes the tag on the last word.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for a miss; latches the line address on miss_req
// S_REQUEST | mem_request held with the line-aligned address until mem_ack
// S_FILL    | each valid beat writes one word; the last beat also writes the tag
// S_DONE    | fill_done pulse; the victim rotates to the next way
module icache_fill_ctrl #(
  parameter int WAYS            = 2,
  parameter int LINE_ADDR_W     = 6,
  parameter int SUB_LINE_ADDR_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  icache_fill_ctrl_if.master bus
);
  localparam int OFF  = SUB_LINE_ADDR_W + 2;
  localparam int LA_W = 32 - OFF;

  typedef enum logic [1:0] {S_IDLE, S_REQUEST, S_FILL, S_DONE} state_t;

  state_t                     state_q, state_d;
  logic [LA_W-1:0]            line_q, line_d;
  logic [SUB_LINE_ADDR_W-1:0] cnt_q, cnt_d;
  logic [WAYS-1:0]            victim_q, victim_d;

  logic            mem_request;
  logic [WAYS-1:0] wen;
  logic            update;
  logic [WAYS-1:0] update_way;
  logic            fill_done;

  // The byte offset inside a line never reaches the memory or the banks.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.miss_addr[OFF-1:0];

  // State, latched line address, word counter and victim way. The line address needs no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      victim_q <= WAYS'(1);
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      victim_q <= victim_d;
    end
    line_q <= line_d;
  end

  // Next-state logic and the strobes driven in each state.
  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    cnt_d       = cnt_q;
    victim_d    = victim_q;
    mem_request = 1'b0;
    wen         = '0;
    update      = 1'b0;
    update_way  = '0;
    fill_done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.miss_req) begin
          line_d  = bus.miss_addr[31:OFF];
          state_d = S_REQUEST;
        end
      end
      S_REQUEST: begin
        mem_request = 1'b1;
        if (bus.mem_ack) begin
          cnt_d   = '0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (bus.mem_data_valid) begin
          wen   = victim_q;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            update     = 1'b1;
            update_way = victim_q;
            state_d    = S_DONE;
          end
        end
      end
      S_DONE: begin
        fill_done = 1'b1;
        victim_d  = {victim_q[WAYS-2:0], victim_q[WAYS-1]};
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.mem_request    = mem_request;
  assign bus.mem_addr       = {line_q, {OFF{1'b0}}};
  assign bus.data_bank_wen  = wen;
  assign bus.data_bank_addr = {line_q[LINE_ADDR_W-1:0], cnt_q};
  assign bus.data_bank_data = bus.mem_data;
  assign bus.update         = update;
  assign bus.update_way     = update_way;
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.fill_done      = fill_done;
endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Bench for icache_fill_ctrl. Inputs change just after the falling edge. Outputs are checked
// 1 ns before the next rising edge.
module tb_icache_fill_ctrl;
  localparam int WAYS  = 2;
  localparam int LAW   = 6;
  localparam int SLW   = 2;
  localparam int WORDS = 1 << SLW;
  localparam logic [31:0] LINE_MASK = ~((32'd1 << (SLW + 2)) - 32'd1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_fill_ctrl_if #(.WAYS(WAYS), .LINE_ADDR_W(LAW), .SUB_LINE_ADDR_W(SLW)) bus ();

  icache_fill_ctrl #(.WAYS(WAYS), .LINE_ADDR_W(LAW), .SUB_LINE_ADDR_W(SLW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  // Reference model: completed fills since the last reset select the round-robin victim.
  int fills = 0;

  function automatic logic [WAYS-1:0] exp_victim();
    return WAYS'(1) << (fills % WAYS);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic exp_outs(input string ph, input logic req, input logic [WAYS-1:0] wen,
                          input logic upd, input logic [WAYS-1:0] uway, input logic done,
                          input logic bsy);
    chk({ph, ".mem_request"}, 32'(bus.mem_request), 32'(req));
    chk({ph, ".wen"},         32'(bus.data_bank_wen), 32'(wen));
    chk({ph, ".update"},      32'(bus.update), 32'(upd));
    chk({ph, ".update_way"},  32'(bus.update_way), 32'(uway));
    chk({ph, ".fill_done"},   32'(bus.fill_done), 32'(done));
    chk({ph, ".busy"},        32'(bus.busy), 32'(bsy));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b0;
      bus.miss_req = 1'b0;
      bus.miss_addr = $urandom;
      bus.mem_ack = 1'b0;
      bus.mem_data_valid = 1'(($urandom % 2));
      bus.mem_data = $urandom;
      #4;
      exp_outs("idle", 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    end
  endtask

  // One miss: ack after ack_dly request cycles, 0 or 1..max_bub bubbles before each beat,
  // optional valid beats during REQUEST, optional miss noise during FILL, optional reset
  // after beat rst_after.
  task automatic do_fill(input logic [31:0] addr, input int ack_dly, input int max_bub,
                         input bit spur, input bit noise, input bit fixed, input int rst_after);
    logic [WAYS-1:0]    v;
    logic [31:0]        d;
    logic [SLW-1:0]     kw;
    logic [LAW+SLW-1:0] exp_ba;
    int                 bub;
    v = exp_victim();
    @(negedge clk);
    rst = 1'b0;
    bus.miss_req = 1'b1;
    bus.miss_addr = addr;
    bus.mem_ack = 1'b0;
    bus.mem_data_valid = spur ? 1'(($urandom % 2)) : 1'b0;
    #4;
    exp_outs("accept", 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i <= ack_dly; i++) begin
      @(negedge clk);
      bus.mem_ack = (i == ack_dly);
      bus.mem_data_valid = spur ? 1'(($urandom % 2)) : 1'b0;
      bus.mem_data = $urandom;
      #4;
      exp_outs("request", 1'b1, '0, 1'b0, '0, 1'b0, 1'b1);
      chk("mem_addr", bus.mem_addr, addr & LINE_MASK);
    end
    for (int k = 0; k < WORDS; k++) begin
      kw = SLW'(k);
      bub = (max_bub == 0) ? 0 : int'($urandom_range(max_bub, 1));
      for (int b = 0; b < bub; b++) begin
        @(negedge clk);
        bus.mem_ack = 1'b0;
        bus.mem_data_valid = 1'b0;
        if (noise) begin
          bus.miss_req = 1'(($urandom % 2));
          bus.miss_addr = $urandom;
        end
        #4;
        exp_outs("bubble", 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      end
      @(negedge clk);
      bus.mem_ack = 1'b0;
      bus.mem_data_valid = 1'b1;
      d = fixed ? (32'hA0 + 32'(k)) : $urandom;
      bus.mem_data = d;
      if (noise) begin
        bus.miss_req = 1'b1;
        bus.miss_addr = $urandom;
      end
      #4;
      exp_outs("beat", 1'b0, v, (k == WORDS - 1), (k == WORDS - 1) ? v : '0, 1'b0, 1'b1);
      exp_ba = {addr[LAW+SLW+1:SLW+2], kw};
      chk("bank_addr", 32'(bus.data_bank_addr), 32'(exp_ba));
      chk("bank_data", bus.data_bank_data, d);
      if (rst_after == k) begin
        @(negedge clk);
        bus.mem_data_valid = 1'b0;
        bus.miss_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #4;
        exp_outs("post_rst", 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        fills = 0;
        return;
      end
    end
    @(negedge clk);
    bus.mem_data_valid = 1'(($urandom % 2));
    bus.miss_req = 1'b1;
    bus.miss_addr = addr;
    #4;
    exp_outs("done", 1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    fills++;
  endtask

  initial begin
    rst = 1'b1;
    bus.miss_req = 1'b0;
    bus.miss_addr = '0;
    bus.mem_ack = 1'b0;
    bus.mem_data_valid = 1'b0;
    bus.mem_data = '0;
    repeat (3) @(negedge clk);
    idle_cycles(5);
    // directed line at 0x1234: ack two cycles after the request, words 0xA0..0xA3 back-to-back
    do_fill(32'h0000_1234, 2, 0, 1'b0, 1'b0, 1'b1, -1);
    // back-to-back misses: the victim wraps
    for (int i = 0; i < 3; i++) do_fill($urandom, 0, 0, 1'b0, 1'b0, 1'b0, -1);
    // bubbles between beats and valid beats during REQUEST
    do_fill($urandom, 1, 3, 1'b1, 1'b0, 1'b0, -1);
    // miss noise during FILL
    do_fill($urandom, 1, 2, 1'b0, 1'b1, 1'b0, -1);
    // one more fill so the victim is not way 0 before the reset
    do_fill($urandom, 0, 1, 1'b0, 1'b0, 1'b0, -1);
    // reset after word 2, then a full fill from way 0
    do_fill($urandom, 0, 0, 1'b0, 1'b0, 1'b0, 2);
    do_fill($urandom, 1, 0, 1'b0, 1'b0, 1'b0, -1);
    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      if ($urandom % 3 == 0) idle_cycles(int'($urandom_range(3, 1)));
      do_fill($urandom, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
              1'(($urandom % 2)), 1'(($urandom % 2)), 1'b0,
              ($urandom % 8 == 0) ? int'($urandom_range(WORDS - 1, 0)) : -1);
    end
    idle_cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
